// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_TEN  = 4'd10;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FIX    = 2'd1,
    EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of a + (9 - b) + cin with decimal carry out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t d,
  output logic       cout
);

  bcd_digit_t nb;
  logic [4:0] t;

  assign nb   = BCD_NINE - b;
  assign t    = {1'b0, a} + {1'b0, nb} + {4'd0, cin};
  assign cout = t >= {1'b0, BCD_TEN};
  assign d    = cout ? t[3:0] - BCD_TEN : t[3:0];

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor A-B, sign/magnitude result, LSD first.
// Define BCD_SUB_ERR_CHECK_EN to flag non-BCD input digits on out_err.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a_digit,
  input  logic [3:0] b_digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_last,
  output logic       out_neg,
  output logic       out_err
);

  localparam int CW = $clog2(NDIGITS);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic           c;
  logic           neg;
  bcd_digit_t     dbuf [NDIGITS];

  bcd_digit_t     sub_a;
  bcd_digit_t     sub_b;
  bcd_digit_t     sub_d;
  logic           sub_c;
  logic           last;
  logic           in_fire;
  logic           out_fire;
  logic [CW-1:0]  cnt_inc;

  assign last     = cnt == CW'(NDIGITS - 1);
  assign cnt_inc  = last ? '0 : cnt + CW'(1);
  assign in_fire  = (state == ACCEPT) && in_valid;
  assign out_fire = (state == EMIT) && out_ready;

  // FIX reuses the digit unit as 0 + (9 - r) + k to form the ten's complement.
  assign sub_a = (state == FIX) ? '0 : a_digit;
  assign sub_b = (state == FIX) ? dbuf[cnt] : b_digit;

  bcd_digit_sub u_sub (
    .a    (sub_a),
    .b    (sub_b),
    .cin  (c),
    .d    (sub_d),
    .cout (sub_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT: if (in_fire && last) state_nxt = sub_c ? EMIT : FIX;
      FIX:    if (last) state_nxt = EMIT;
      EMIT:   if (out_fire && last) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
      cnt   <= '0;
      c     <= 1'b1;
      neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCEPT: if (in_fire) begin
          cnt <= cnt_inc;
          c   <= last ? 1'b1 : sub_c;
          if (last) neg <= ~sub_c;
        end
        FIX: begin
          cnt <= cnt_inc;
          c   <= last ? 1'b1 : sub_c;
        end
        EMIT: if (out_fire) cnt <= cnt_inc;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire || (state == FIX)) dbuf[cnt] <= sub_d;
  end

`ifdef BCD_SUB_ERR_CHECK_EN
  logic err;
  logic bad;

  assign bad = (a_digit > BCD_NINE) || (b_digit > BCD_NINE);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_fire) begin
      err <= (cnt == '0) ? bad : (err | bad);
    end
  end

  assign out_err = err;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = state == ACCEPT;
  assign out_valid = state == EMIT;
  assign out_digit = (state == EMIT) ? dbuf[cnt] : '0;
  assign out_last  = (state == EMIT) && last;
  assign out_neg   = neg;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Randomized self-checking bench for bcd_sub_serial against an integer model.
module tb_bcd_sub_serial;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_digit;
  logic [3:0] b_digit;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_last;
  logic       out_neg;
  logic       out_err;

  int tests = 0;
  int fails = 0;

  bcd_sub_serial #(.NDIGITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_digit   (a_digit),
    .b_digit   (b_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Drives one operation and collects what the DUT emits.
  task automatic do_op(
    input  int a, input int b, input int badpos, input int stall,
    output int res, output bit neg, output bit err, output bit stable,
    output int lat, output bit last_ok, output bit hold_ok,
    output bit rdy_after, output bit to);
    int cnt;
    int p10;
    logic [3:0] hd;
    logic hl, hn, he;
    res = 0; neg = 0; err = 0; stable = 1; lat = 0;
    last_ok = 1; hold_ok = 1; rdy_after = 0; to = 0;
    out_ready = 0;
    p10 = 1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      a_digit  = 4'((a / p10) % 10);
      b_digit  = (i == badpos) ? 4'hC : 4'((b / p10) % 10);
      in_valid = 1;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (!in_ready) to = 1;
      @(posedge clk);
      p10 *= 10;
    end
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      to = 1;
      return;
    end
    p10 = 1;
    for (int i = 0; i < N; i++) begin
      if (!out_valid) to = 1;
      if (i == 1 && stall > 0) begin
        hd = out_digit; hl = out_last; hn = out_neg; he = out_err;
        out_ready = 0;
        repeat (stall) begin
          @(negedge clk);
          if (!out_valid || out_digit !== hd || out_last !== hl ||
              out_neg !== hn || out_err !== he || in_ready !== 1'b0)
            hold_ok = 0;
        end
      end
      out_ready = 1;
      res += int'(out_digit) * p10;
      if (i == 0) begin
        neg = out_neg;
        err = out_err;
      end else if (out_neg !== neg || out_err !== err) begin
        stable = 0;
      end
      if (out_last !== (i == N - 1)) last_ok = 0;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
      p10 *= 10;
    end
    rdy_after = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; a_digit = 0; b_digit = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_last, out_neg, out_err, out_digit} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL reset: got rdy=%0b v=%0b last=%0b neg=%0b err=%0b d=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, out_last, out_neg, out_err, out_digit);
    end
    rst = 0;
  endtask

  // Runs one operation and checks everything against the integer model.
  task automatic check_op(input string nm, input int a, input int b, input int stall);
    int res, lat, exp_res, exp_lat;
    bit neg, err, st, lok, hok, rdy, to, exp_neg;
    exp_neg = a < b;
    exp_res = exp_neg ? b - a : a - b;
    exp_lat = exp_neg ? N + 1 : 1;
    do_op(a, b, -1, stall, res, neg, err, st, lat, lok, hok, rdy, to);
    tests++;
    if (to || res != exp_res || neg !== exp_neg || lat != exp_lat) begin
      fails++;
      $display("FAIL %s %0d-%0d: got mag=%0d neg=%0b lat=%0d to=%0b want mag=%0d neg=%0b lat=%0d",
               nm, a, b, res, neg, lat, to, exp_res, exp_neg, exp_lat);
    end
    tests++;
    if (!(st && lok && hok && rdy) || err !== 1'b0) begin
      fails++;
      $display("FAIL %s_flags %0d-%0d: got stable=%0b last=%0b hold=%0b rdy=%0b err=%0b want 1 1 1 1 0",
               nm, a, b, st, lok, hok, rdy, err);
    end
  endtask

  task automatic test_vectors();
    check_op("pos", 42, 17, 0);
    check_op("neg", 17, 42, 0);
    check_op("zero_minus", 0, 9999, 0);
    check_op("equal", 3141, 3141, 0);
    check_op("max_pos", 9999, 0, 0);
    check_op("borrow_chain", 1000, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      check_op("random", int'($urandom_range(9999)), int'($urandom_range(9999)),
               int'($urandom_range(2)));
  endtask

  task automatic test_backpressure();
    check_op("stall_pos", 42, 17, 3);
    check_op("stall_neg", 17, 42, 3);
  endtask

  task automatic test_err();
    int res, lat;
    bit neg, err, st, lok, hok, rdy, to, exp_err;
`ifdef BCD_SUB_ERR_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_op(42, 17, 2, 0, res, neg, err, st, lat, lok, hok, rdy, to);
    tests++;
    if (to || err !== exp_err || !st || !lok) begin
      fails++;
      $display("FAIL err_flag: got err=%0b stable=%0b last=%0b to=%0b want err=%0b stable=1 last=1",
               err, st, lok, to, exp_err);
    end
    do_op(42, 17, -1, 0, res, neg, err, st, lat, lok, hok, rdy, to);
    tests++;
    if (to || err !== 1'b0 || res != 25 || neg !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got err=%0b mag=%0d neg=%0b want err=0 mag=25 neg=0",
               err, res, neg);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_digit = 4'd3; b_digit = 4'd8; in_valid = 1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0; rst = 1; out_ready = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    out_ready = 0;
    tests++;
    if (seen || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: got out_valid_seen=%0b in_ready=%0b want 0 1", seen, in_ready);
    end
    check_op("after_rst", 42, 17, 0);
  endtask

  initial begin
    in_valid = 0; out_ready = 0; a_digit = 0; b_digit = 0; rst = 1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
